// File: rtl/vm_credit_controller.sv
// rtl/vm_credit_controller.sv - vending-machine credit total, inactivity timer and greedy change return
// Optional user-triggered return is enabled with the VM_TRIGGER_RETURN_EN macro.
module vm_credit_controller #(
  parameter int NUM_ITEMS   = 4,
  parameter int NUM_COINS   = 3,
  parameter int TOTAL_BITS  = 16,
  parameter int WAIT_CYCLES = 100
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic [NUM_ITEMS-1:0]            i_select_item,
  input  logic [NUM_ITEMS*TOTAL_BITS-1:0] i_item_price,
  input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value,
`ifdef VM_TRIGGER_RETURN_EN
  input  logic                            i_trigger_return,
`endif
  output logic [NUM_ITEMS-1:0]            o_available_item,
  output logic [NUM_ITEMS-1:0]            o_output_item,
  output logic [NUM_COINS-1:0]            o_return_coin,
  output logic [TOTAL_BITS-1:0]           o_current_total,
  output logic [1:0]                      o_state
);

  localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int CW = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam int TW = $clog2(WAIT_CYCLES + 1) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RETURN  = 2'd2,
    ST_UNUSED  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [TOTAL_BITS-1:0] total, total_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [NUM_ITEMS-1:0]  out_item, out_item_nxt;
  logic [NUM_COINS-1:0]  ret_coin, ret_coin_nxt;

  logic [TOTAL_BITS-1:0] price    [NUM_ITEMS];
  logic [TOTAL_BITS-1:0] coin_val [NUM_COINS];

  logic                  trig;
  logic                  coin_valid, sel_valid, sel_ok, coin_ok, ret_valid;
  logic [CW-1:0]         coin_idx, ret_idx;
  logic [IW-1:0]         sel_idx;
  logic [NUM_ITEMS-1:0]  avail;
  logic [TOTAL_BITS-1:0] base;
  logic [TOTAL_BITS:0]   sum;

`ifdef VM_TRIGGER_RETURN_EN
  assign trig = i_trigger_return;
`else
  assign trig = 1'b0;
`endif

  always_comb begin
    for (int k = 0; k < NUM_ITEMS; k++) begin
      price[k] = i_item_price[k*TOTAL_BITS +: TOTAL_BITS];
    end
    for (int c = 0; c < NUM_COINS; c++) begin
      coin_val[c] = i_coin_value[c*TOTAL_BITS +: TOTAL_BITS];
    end
  end

  // Descending scans leave the lowest set index; the return scan ascends to keep the largest coin.
  always_comb begin
    coin_valid = 1'b0;
    coin_idx   = '0;
    for (int c = NUM_COINS - 1; c >= 0; c--) begin
      if (i_input_coin[c]) begin
        coin_valid = 1'b1;
        coin_idx   = CW'(c);
      end
    end
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
      if (i_select_item[k]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(k);
      end
    end
    ret_valid = 1'b0;
    ret_idx   = '0;
    for (int c = 0; c < NUM_COINS; c++) begin
      if (coin_val[c] <= total) begin
        ret_valid = 1'b1;
        ret_idx   = CW'(c);
      end
    end
    for (int k = 0; k < NUM_ITEMS; k++) begin
      avail[k] = (state == ST_COLLECT) && (total >= price[k]);
    end
  end

  // Selection is judged against the registered total; a same-cycle coin is added after the price.
  always_comb begin
    sel_ok  = sel_valid && avail[sel_idx];
    base    = sel_ok ? (total - price[sel_idx]) : total;
    sum     = {1'b0, base} + {1'b0, coin_val[coin_idx]};
    coin_ok = coin_valid && !sum[TOTAL_BITS];
  end

  always_comb begin
    state_nxt    = state;
    total_nxt    = total;
    timer_nxt    = timer;
    out_item_nxt = '0;
    ret_coin_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (coin_valid) begin
          state_nxt = ST_COLLECT;
          total_nxt = coin_val[coin_idx];
          timer_nxt = TW'(WAIT_CYCLES);
        end
      end
      ST_COLLECT: begin
        if (trig) begin
          state_nxt = ST_RETURN;
          timer_nxt = '0;
        end else begin
          if (sel_ok) out_item_nxt = NUM_ITEMS'(1) << sel_idx;
          if (coin_valid && !coin_ok) ret_coin_nxt = NUM_COINS'(1) << coin_idx;
          total_nxt = coin_ok ? sum[TOTAL_BITS-1:0] : base;
          if (sel_ok || coin_ok) begin
            timer_nxt = TW'(WAIT_CYCLES);
          end else if (timer <= TW'(1)) begin
            state_nxt = ST_RETURN;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
      end
      ST_RETURN: begin
        if (ret_valid) begin
          ret_coin_nxt = NUM_COINS'(1) << ret_idx;
          total_nxt    = total - coin_val[ret_idx];
          if (total == coin_val[ret_idx]) state_nxt = ST_IDLE;
        end else begin
          // Remainder smaller than the smallest coin cannot be paid out.
          total_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        total_nxt = '0;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      total    <= '0;
      timer    <= '0;
      out_item <= '0;
      ret_coin <= '0;
    end else begin
      state    <= state_nxt;
      total    <= total_nxt;
      timer    <= timer_nxt;
      out_item <= out_item_nxt;
      ret_coin <= ret_coin_nxt;
    end
  end

  assign o_available_item = avail;
  assign o_output_item    = out_item;
  assign o_return_coin    = ret_coin;
  assign o_current_total  = total;
  assign o_state          = state;

endmodule

// File: doc/vm_credit_controller.md
# vm_credit_controller

Parametrised vending-machine credit controller: it owns the credit total, the inactivity timer and the change-return sequencer. It generalises the fixed 4-item/3-coin state calculation to NUM_ITEMS items and NUM_COINS coin types. It adds saturating credit with rejected-coin echo, multi-cycle greedy change return and an optional user-triggered return. It sits between the coin/selection front-end and the dispenser/coin-hopper drivers.

## Interface
- NUM_ITEMS, 4, number of item types.
- NUM_COINS, 3, number of coin types.
- TOTAL_BITS, 16, width of the credit total, prices and coin values.
- WAIT_CYCLES, 100, inactivity timeout in cycles; must be ≥1.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- i_input_coin  in  NUM_COINS  one-hot coin-inserted strobe, one cycle per coin.
- i_select_item  in  NUM_ITEMS  item-select strobe; if several bits are set, the lowest index wins.
- i_item_price  in  NUM_ITEMS*TOTAL_BITS  flattened price table; item k occupies bits [k*TOTAL_BITS +: TOTAL_BITS].
- i_coin_value  in  NUM_COINS*TOTAL_BITS  flattened coin values, strictly ascending by index and nonzero.
- i_trigger_return  in  1  request immediate change return; present only with VM_TRIGGER_RETURN_EN.
- o_available_item  out  NUM_ITEMS  combinational; bit k = (state==COLLECT) && (total ≥ price[k]).
- o_output_item  out  NUM_ITEMS  registered one-cycle dispense pulse.
- o_return_coin  out  NUM_COINS  registered one-hot, one-cycle coin-return pulse.
- o_current_total  out  TOTAL_BITS  registered credit total.
- o_state  out  2  IDLE=0, COLLECT=1, RETURN=2; encoding 3 is unused and recovers to IDLE.

## Operation
- Reset values: state IDLE; total, timer, o_output_item and o_return_coin are 0; o_available_item is 0.
- IDLE: a coin credits its value, the block goes to COLLECT and the timer loads WAIT_CYCLES. Selects are ignored.
- COLLECT, coin: sum = total + value. If sum ≤ 2^TOTAL_BITS−1, the coin is credited and the timer reloads. Otherwise the total is unchanged, the same coin bit pulses on o_return_coin the next cycle and the timer does not reload.
- COLLECT, select: the winning item is checked against the registered total, i.e. before any coin in the same cycle.
  - If available: o_output_item pulses that bit, the price is subtracted and the timer reloads.
  - If unavailable: the select is ignored.
- COLLECT, simultaneous coin and valid select: both apply in one update, total_nxt = total + value − price. The overflow check uses total − price + value.
- COLLECT, no accepted event: the timer decrements. When the timer is 1 and the cycle has no accepted event, the next state is RETURN.
- RETURN: each cycle the block picks the highest-index coin with value ≤ total. It pulses that bit on o_return_coin and subtracts the value.
  - When total reaches 0, the next state is IDLE.
  - If total > 0 but less than coin_value[0], the remainder is discarded (total := 0) and the next state is IDLE.
  - Coins and selects are ignored during RETURN: no credit, no echo.
- The total never wraps: subtraction happens only when total ≥ operand, and addition is guarded by the overflow check.

## Timing
- Accepted coin or dispense at edge k: o_current_total reflects it after edge k. o_output_item is high for exactly the cycle following edge k.
- Last accepted event at edge k with no further events: the state becomes RETURN at edge k+WAIT_CYCLES. The first o_return_coin pulse follows edge k+WAIT_CYCLES+1, then one coin per cycle.
- o_available_item follows o_current_total and o_state combinationally, with no added latency.
- Reset asserted mid-RETURN or mid-dispense: all outputs drop to their reset values asynchronously. A partially returned credit is lost.

## Configuration
- VM_TRIGGER_RETURN_EN defined:
  - Adds the i_trigger_return port.
  - In COLLECT, i_trigger_return=1 forces RETURN at the next edge and takes priority over same-cycle coins and selects, which are ignored.
  - In IDLE and RETURN it has no effect.
- VM_TRIGGER_RETURN_EN undefined: the port is absent and RETURN is entered only by timeout.

## Test plan
Common setup: NUM_ITEMS=4, NUM_COINS=3, coin values {100,500,1000}, prices {400,500,1000,2000}, WAIT_CYCLES=10, TOTAL_BITS=16 except where stated.
- Insert coin 2 (1000), then select 4'b0010:
  - after the coin: o_available_item=4'b0111;
  - after the select: one-cycle o_output_item=4'b0010 and o_current_total=500.
- Total 500 in COLLECT; same cycle coin 0 (100) and select 4'b0011 → o_output_item=4'b0001 (lowest index wins), total=200.
- Insert 500 then 100, then idle → RETURN exactly 10 cycles after the last coin; o_return_coin=3'b010 then 3'b001; total=0; state IDLE.
- TOTAL_BITS=12: insert 1000 four times (4000), then 100 → not credited, o_return_coin=3'b001 next cycle, total stays 4000.
- Assert reset asynchronously between the two return pulses of the timeout case → total=0, state IDLE, o_return_coin=0 with no clock edge required.
- With VM_TRIGGER_RETURN_EN: total 600, pulse i_trigger_return together with coin 0 → coin ignored, RETURN next edge, returns 3'b010 then 3'b001.
